move_step_ctrl: RTL and testbench

- Synchronous controller for the player's horizontal position in the falling-floors game.
- Inputs are raw left/right push buttons. The block synchronises and debounces them, arbitrates between the two directions, and applies pause.
- Adds hold-to-repeat stepping and keeps a bounded signed step counter.
- Drives the signed pixel offset and facing flag consumed by the sprite renderer. Replaces per-button edge-clocked counters with a single-clock design.

---
 rtl/move_step_ctrl_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 50 +++++
 rtl/move_step_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_move_step_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/move_step_ctrl_pkg.sv
// Shared definitions for the player movement controller and its consumers.
package move_step_ctrl_pkg;

   // Hold/repeat FSM state encoding.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StHoldL = 2'd1,
      StHoldR = 2'd2
   } move_state_e;

   // Direction of a requested step.
   typedef enum logic [1:0] {
      DirNone  = 2'd0,
      DirLeft  = 2'd1,
      DirRight = 2'd2
   } move_dir_e;

   // Geometry defaults also used by the renderer and collision logic.
   localparam int STEP_DEFAULT      = 25;
   localparam int MAX_STEPS_DEFAULT = 11;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw button.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic clean
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             clean_q, clean_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count cycles of disagreement; the clean level flips on the cycle the count hits the limit.
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      clean_d = clean_q;
      cnt_d   = '0;
      if (sync2_q != clean_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
            clean_d = ~clean_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Synchroniser and debounce state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         clean_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         clean_q <= clean_d;
         cnt_q   <= cnt_d;
      end
   end

   assign clean = clean_q;

endmodule

// File: rtl/move_step_ctrl.sv
// Player horizontal position controller: debounced buttons, hold-to-repeat stepping,
// clamped signed step count and registered pixel offset.
module move_step_ctrl
   import move_step_ctrl_pkg::*;
#(
   parameter int          STEP         = STEP_DEFAULT,
   parameter int          MAX_STEPS    = MAX_STEPS_DEFAULT,
   parameter int unsigned DEBOUNCE_CYC = 16,
   parameter int unsigned REPEAT_FIRST = 6000000,
   parameter int unsigned REPEAT_NEXT  = 2500000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pause,
   input  logic               left_btn,
   input  logic               right_btn,
   output logic signed [11:0] rel_xx,
   output logic               face_RL,
   output logic               at_left_edge,
   output logic               at_right_edge,
   output logic               move_pulse
);

   localparam int unsigned RPT_MAX = (REPEAT_FIRST > REPEAT_NEXT) ? REPEAT_FIRST : REPEAT_NEXT;
   localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

   localparam logic signed [4:0]  POS_MAX = 5'(MAX_STEPS);
   localparam logic signed [4:0]  POS_MIN = -POS_MAX;
   localparam logic signed [11:0] STEP_S  = 12'(STEP);

   logic left_clean, right_clean;

   btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
   ) u_left_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (left_btn),
      .clean(left_clean)
   );

   btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
   ) u_right_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (right_btn),
      .clean(right_clean)
   );

   move_state_e        state_q, state_d;
   logic [RPT_W-1:0]   rpt_q, rpt_d;
   logic signed [4:0]  pos_q, pos_d;
   logic               face_q, face_d;
   logic               pulse_q, pulse_d;
   logic signed [11:0] rel_q, rel_d;
   logic               left_prev_q, left_prev_d;
   logic               right_prev_q, right_prev_d;

   logic      rise_l, fall_l, rise_r, fall_r;
   move_dir_e press_dir;
   move_dir_e step_dir;
   logic      repeat_fire;

   assign rise_l = left_clean & ~left_prev_q;
   assign fall_l = ~left_clean & left_prev_q;
   assign rise_r = right_clean & ~right_prev_q;
   assign fall_r = ~right_clean & right_prev_q;

   // Next-state: arbitration, repeat timing, clamped stepping and facing.
   always_comb begin
      state_d      = state_q;
      rpt_d        = rpt_q;
      pos_d        = pos_q;
      face_d       = face_q;
      pulse_d      = 1'b0;
      left_prev_d  = left_clean;
      right_prev_d = right_clean;
      rel_d        = STEP_S * 12'(pos_q);
      press_dir    = DirNone;
      repeat_fire  = 1'b0;

      case (state_q)
         StIdle: begin
            if (rise_l && rise_r) begin
               // Tie goes to the direction already faced.
               press_dir = face_q ? DirRight : DirLeft;
            end else if (rise_l) begin
               press_dir = DirLeft;
            end else if (rise_r) begin
               press_dir = DirRight;
            end
         end
         StHoldL: begin
            if (rise_r) begin
               press_dir = DirRight;
            end else if (fall_l) begin
               state_d = StIdle;
            end else if (!pause) begin
               if (rpt_q <= RPT_W'(1)) begin
                  repeat_fire = 1'b1;
               end else begin
                  rpt_d = rpt_q - RPT_W'(1);
               end
            end
         end
         StHoldR: begin
            if (rise_l) begin
               press_dir = DirLeft;
            end else if (fall_r) begin
               state_d = StIdle;
            end else if (!pause) begin
               if (rpt_q <= RPT_W'(1)) begin
                  repeat_fire = 1'b1;
               end else begin
                  rpt_d = rpt_q - RPT_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase

      step_dir = press_dir;
      if (press_dir == DirLeft) begin
         state_d = StHoldL;
      end else if (press_dir == DirRight) begin
         state_d = StHoldR;
      end
      // The repeat counter stays frozen while paused, including on a new press.
      if (press_dir != DirNone && !pause) begin
         rpt_d = RPT_W'(REPEAT_FIRST);
      end
      if (repeat_fire) begin
         rpt_d    = RPT_W'(REPEAT_NEXT);
         step_dir = (state_q == StHoldL) ? DirLeft : DirRight;
      end

      // Facing follows every accepted step; position moves only if unpaused and in range.
      if (step_dir == DirLeft) begin
         face_d = 1'b0;
         if (!pause && (pos_q < POS_MAX)) begin
            pos_d   = pos_q + 5'sd1;
            pulse_d = 1'b1;
         end
      end else if (step_dir == DirRight) begin
         face_d = 1'b1;
         if (!pause && (pos_q > POS_MIN)) begin
            pos_d   = pos_q - 5'sd1;
            pulse_d = 1'b1;
         end
      end
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         rpt_q        <= '0;
         pos_q        <= '0;
         face_q       <= 1'b1;
         pulse_q      <= 1'b0;
         rel_q        <= '0;
         left_prev_q  <= 1'b0;
         right_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rpt_q        <= rpt_d;
         pos_q        <= pos_d;
         face_q       <= face_d;
         pulse_q      <= pulse_d;
         rel_q        <= rel_d;
         left_prev_q  <= left_prev_d;
         right_prev_q <= right_prev_d;
      end
   end

   assign rel_xx        = rel_q;
   assign face_RL       = face_q;
   assign move_pulse    = pulse_q;
   assign at_left_edge  = (pos_q == POS_MAX);
   assign at_right_edge = (pos_q == POS_MIN);

endmodule

// File: tb/tb_move_step_ctrl.sv
// Scoreboard bench for move_step_ctrl with shortened debounce/repeat timing.
module tb_move_step_ctrl;

   logic               clk;
   logic               rst;
   logic               pause;
   logic               left_btn;
   logic               right_btn;
   logic signed [11:0] rel_xx;
   logic               face_RL;
   logic               at_left_edge;
   logic               at_right_edge;
   logic               move_pulse;

   move_step_ctrl #(
      .STEP        (25),
      .MAX_STEPS   (11),
      .DEBOUNCE_CYC(4),
      .REPEAT_FIRST(8),
      .REPEAT_NEXT (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pause        (pause),
      .left_btn     (left_btn),
      .right_btn    (right_btn),
      .rel_xx       (rel_xx),
      .face_RL      (face_RL),
      .at_left_edge (at_left_edge),
      .at_right_edge(at_right_edge),
      .move_pulse   (move_pulse)
   );

   typedef struct {
      int cyc;
      int rel;
      int face;
      int le;
      int re;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic expect_pulse(input int c, input int rel, input int face, input int le,
                               input int re);
      exp_t e;
      e.cyc  = c;
      e.rel  = rel;
      e.face = face;
      e.le   = le;
      e.re   = re;
      exp_q.push_back(e);
   endtask

   // Monitor: every move_pulse pops one expectation; rel_xx is checked one cycle later.
   initial begin
      exp_t e;
      int   rel_pend;
      bit   pend;
      pend = 1'b0;
      rel_pend = 0;
      forever begin
         @(negedge clk);
         if (pend) begin
            check("rel_after_pulse", int'(rel_xx), rel_pend);
            pend = 1'b0;
         end
         if (move_pulse) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_pulse: got pulse expected none (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               check("pulse_cycle", cyc, e.cyc);
               check("pulse_face", int'(face_RL), e.face);
               check("pulse_left_edge", int'(at_left_edge), e.le);
               check("pulse_right_edge", int'(at_right_edge), e.re);
               rel_pend = e.rel;
               pend = 1'b1;
            end
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_rel"}, int'(rel_xx), 0);
      check({tag, "_face"}, int'(face_RL), 1);
      check({tag, "_ledge"}, int'(at_left_edge), 0);
      check({tag, "_redge"}, int'(at_right_edge), 0);
      check({tag, "_pulse"}, int'(move_pulse), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_vals("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Drives from the current negedge: index 0 is sampled at the next posedge.
   task automatic run_pattern(input int l_on, input int l_off, input int r_on, input int r_off,
                              input int p_on, input int p_off, input int total);
      for (int i = 0; i < total; i++) begin
         left_btn  = (i >= l_on) && (i < l_off);
         right_btn = (i >= r_on) && (i < r_off);
         pause     = (i >= p_on) && (i < p_off);
         @(negedge clk);
      end
      left_btn  = 1'b0;
      right_btn = 1'b0;
      pause     = 1'b0;
   endtask

   task automatic phase_end(input string tag, input int rel, input int face, input int le,
                            input int re);
      check({tag, "_pending"}, exp_q.size(), 0);
      check({tag, "_rel"}, int'(rel_xx), rel);
      check({tag, "_face"}, int'(face_RL), face);
      check({tag, "_ledge"}, int'(at_left_edge), le);
      check({tag, "_redge"}, int'(at_right_edge), re);
      exp_q.delete();
   endtask

   initial begin
      int k;
      int r;
      rst       = 1'b1;
      pause     = 1'b0;
      left_btn  = 1'b0;
      right_btn = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("init");
      rst = 1'b0;

      // 3-cycle glitch never reaches the clean level.
      @(negedge clk);
      run_pattern(0, 3, 0, 0, 0, 0, 20);
      phase_end("glitch", 0, 1, 0, 0);

      // Single left press: one step at k+6, rel_xx at k+7.
      @(negedge clk);
      k = cyc + 1;
      expect_pulse(k + 6, 25, 0, 0, 0);
      run_pattern(0, 6, 0, 0, 0, 0, 25);
      phase_end("single_left", 25, 0, 0, 0);

      // Left held 30 cycles: entry then repeats at +8, +12, ... +28.
      do_reset();
      @(negedge clk);
      k = cyc + 1;
      expect_pulse(k + 6, 25, 0, 0, 0);
      for (int j = 1; j <= 6; j++) expect_pulse(k + 10 + 4 * j, 25 * (j + 1), 0, 0, 0);
      run_pattern(0, 30, 0, 0, 0, 0, 50);
      phase_end("repeat_left", 175, 0, 0, 0);

      // Right held until the clamp; later repeats are dropped silently.
      do_reset();
      @(negedge clk);
      k = cyc + 1;
      expect_pulse(k + 6, -25, 1, 0, 0);
      for (int j = 1; j <= 10; j++) begin
         expect_pulse(k + 10 + 4 * j, -25 * (j + 1), 1, 0, (j == 10) ? 1 : 0);
      end
      run_pattern(0, 0, 0, 60, 0, 0, 75);
      phase_end("clamp_right", -275, 1, 0, 1);

      // Left held, right pressed 10 cycles later: right wins and then repeats.
      do_reset();
      @(negedge clk);
      k = cyc + 1;
      expect_pulse(k + 6, 25, 0, 0, 0);
      expect_pulse(k + 14, 50, 0, 0, 0);
      expect_pulse(k + 16, 25, 1, 0, 0);
      expect_pulse(k + 24, 0, 1, 0, 0);
      run_pattern(0, 20, 10, 20, 0, 0, 40);
      phase_end("last_pressed", 0, 1, 0, 0);

      // Simultaneous rises out of reset: facing right, so right wins.
      do_reset();
      @(negedge clk);
      k = cyc + 1;
      expect_pulse(k + 6, -25, 1, 0, 0);
      run_pattern(0, 6, 0, 6, 0, 0, 25);
      phase_end("simultaneous", -25, 1, 0, 0);

      // Pause for 4 cycles mid-repeat delays later repeats by 4 without a reload.
      do_reset();
      @(negedge clk);
      k = cyc + 1;
      expect_pulse(k + 6, 25, 0, 0, 0);
      expect_pulse(k + 14, 50, 0, 0, 0);
      expect_pulse(k + 22, 75, 0, 0, 0);
      expect_pulse(k + 26, 100, 0, 0, 0);
      expect_pulse(k + 30, 125, 0, 0, 0);
      run_pattern(0, 28, 0, 0, 16, 20, 45);
      phase_end("pause", 125, 0, 0, 0);

      // Asynchronous reset mid-hold, then a fresh debounced rise while still held.
      do_reset();
      @(negedge clk);
      k = cyc + 1;
      expect_pulse(k + 6, 25, 0, 0, 0);
      left_btn = 1'b1;
      repeat (10) @(negedge clk);
      check("midhold_before_rst_rel", int'(rel_xx), 25);
      check("midhold_pending", exp_q.size(), 0);
      rst = 1'b1;
      #1;
      check_reset_vals("midhold_rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      r = cyc + 1;
      expect_pulse(r + 6, 25, 0, 0, 0);
      repeat (6) @(negedge clk);
      left_btn = 1'b0;
      repeat (20) @(negedge clk);
      phase_end("after_rst", 25, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
